// File: rtl/rv32i_types.sv
// Shared cache/memory types: cache line, memory beat, adapter FSM states.
package rv32i_types;

   localparam int CACHE_LINE_WIDTH = 256;
   localparam int MEM_BEAT_WIDTH   = 64;

   function automatic int beats_in_line(input int line_width, input int beat_width);
      return line_width / beat_width;
   endfunction

   localparam int BEATS_PER_LINE = beats_in_line(CACHE_LINE_WIDTH, MEM_BEAT_WIDTH);

   typedef logic [CACHE_LINE_WIDTH-1:0] rv32i_cache_line;
   typedef logic [MEM_BEAT_WIDTH-1:0]   rv32i_mem_beat;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } burst_state_e;

endpackage

// File: rtl/line_burst_adapter_if.sv
// Cache-side line port (pmem_*) and memory-side beat bus (burst_*) in one bundle.
interface line_burst_adapter_if
   import rv32i_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH = MEM_BEAT_WIDTH
);

   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_read;
   logic                  pmem_write;
   logic                  pmem_resp;

   logic [ADDR_WIDTH-1:0] burst_address;
   logic [BEAT_WIDTH-1:0] burst_wdata;
   logic [BEAT_WIDTH-1:0] burst_rdata;
   logic                  burst_read;
   logic                  burst_write;
   logic                  burst_resp;

   // The adapter is the slave; cache plus memory together form the master side.
   modport slave (
      input  pmem_address, pmem_wdata, pmem_read, pmem_write,
      input  burst_rdata, burst_resp,
      output pmem_rdata, pmem_resp,
      output burst_address, burst_wdata, burst_read, burst_write
   );

   modport master (
      output pmem_address, pmem_wdata, pmem_read, pmem_write,
      output burst_rdata, burst_resp,
      input  pmem_rdata, pmem_resp,
      input  burst_address, burst_wdata, burst_read, burst_write
   );

endinterface

// File: rtl/line_beat_buffer.sv
// Line storage for the adapter: beat-wise fill for reads, beat-wise select for writes.
module line_beat_buffer
   import rv32i_types::*;
#(
   parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH = MEM_BEAT_WIDTH,
   parameter int IDX_WIDTH  = $clog2(LINE_WIDTH / BEAT_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  line_load,
   input  logic [LINE_WIDTH-1:0] line_in,
   input  logic                  beat_store,
   input  logic [IDX_WIDTH-1:0]  beat_idx,
   input  logic [BEAT_WIDTH-1:0] beat_in,
   output logic [LINE_WIDTH-1:0] rd_line,
   output logic [BEAT_WIDTH-1:0] wr_beat
);

   localparam int BEATS = beats_in_line(LINE_WIDTH, BEAT_WIDTH);

   // Separate read and write lines so a writeback never disturbs the last fill.
   logic [LINE_WIDTH-1:0] rd_line_reg;
   logic [LINE_WIDTH-1:0] wr_line_reg;
   logic [BEAT_WIDTH-1:0] rd_beats_reg [BEATS];
   logic [BEAT_WIDTH-1:0] wr_beats     [BEATS];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_line_reg <= '0;
      end else if (line_load) begin
         wr_line_reg <= line_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BEATS; i++) begin
            rd_beats_reg[i] <= '0;
         end
      end else if (beat_store) begin
         rd_beats_reg[beat_idx] <= beat_in;
      end
   end

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
         assign rd_line_reg[gi*BEAT_WIDTH +: BEAT_WIDTH] = rd_beats_reg[gi];
         assign wr_beats[gi] = wr_line_reg[gi*BEAT_WIDTH +: BEAT_WIDTH];
      end
   endgenerate

   assign rd_line = rd_line_reg;
   assign wr_beat = wr_beats[beat_idx];

endmodule

// File: rtl/line_burst_adapter.sv
// Turns one cache-line read/write request into a burst of memory beats and
// returns a single-cycle pmem_resp once the whole line has moved.
module line_burst_adapter
   import rv32i_types::*;
#(
   parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH = MEM_BEAT_WIDTH,
   parameter int ADDR_WIDTH = 32
) (
   input logic                 clk,
   input logic                 rst,
   line_burst_adapter_if.slave bus
);

   localparam int BEATS    = beats_in_line(LINE_WIDTH, BEAT_WIDTH);
   localparam int CW       = $clog2(BEATS);
   localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   burst_state_e          state_reg, state_next;
   logic [CW-1:0]         count_reg, count_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [ADDR_WIDTH-1:0] line_base;
   logic                  line_load;
   logic                  beat_store;
   logic                  both_req;
   logic [LINE_WIDTH-1:0] rd_line;
   logic [BEAT_WIDTH-1:0] wr_beat;

   assign line_base = {bus.pmem_address[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
   assign both_req  = (state_reg == ST_IDLE) && bus.pmem_read && bus.pmem_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         addr_reg  <= addr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      addr_next  = addr_reg;
      line_load  = 1'b0;
      beat_store = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            count_next = '0;
            // Write wins a simultaneous request so dirty data is never dropped.
            if (bus.pmem_write) begin
               state_next = ST_WRITE;
               addr_next  = line_base;
               line_load  = 1'b1;
            end else if (bus.pmem_read) begin
               state_next = ST_READ;
               addr_next  = line_base;
            end
         end
         ST_READ: begin
            if (bus.burst_resp) begin
               beat_store = 1'b1;
               count_next = count_reg + CW'(1);
               if (count_reg == LAST_BEAT) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_WRITE: begin
            if (bus.burst_resp) begin
               count_next = count_reg + CW'(1);
               if (count_reg == LAST_BEAT) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            count_next = '0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            count_next = '0;
         end
      endcase
   end

   line_beat_buffer #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .IDX_WIDTH  (CW)
   ) u_buffer (
      .clk        (clk),
      .rst        (rst),
      .line_load  (line_load),
      .line_in    (bus.pmem_wdata),
      .beat_store (beat_store),
      .beat_idx   (count_reg),
      .beat_in    (bus.burst_rdata),
      .rd_line    (rd_line),
      .wr_beat    (wr_beat)
   );

   assign bus.burst_address = addr_reg;
   assign bus.burst_read    = (state_reg == ST_READ);
   assign bus.burst_write   = (state_reg == ST_WRITE);
   assign bus.burst_wdata   = (state_reg == ST_WRITE) ? wr_beat : '0;
   assign bus.pmem_resp     = (state_reg == ST_DONE);
   assign bus.pmem_rdata    = rd_line;

   // The cache must never raise both requests together.
   assert property (@(posedge clk) disable iff (rst) !both_req)
      else $warning("line_burst_adapter: pmem_read and pmem_write high together, write taken");

endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: reads, gapped writes, back-to-back,
// reset abort, simultaneous requests and stray idle beat strobes.
module tb_line_burst_adapter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks    = 0;
   int fails     = 0;
   int resp_seen = 0;
   int overlaps  = 0;

   line_burst_adapter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(256), .BEAT_WIDTH(64)) bus ();

   line_burst_adapter #(
      .LINE_WIDTH (256),
      .BEAT_WIDTH (64),
      .ADDR_WIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.pmem_resp) resp_seen++;
      if (bus.burst_read && bus.burst_write) overlaps++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds the four beats of a line on burst_rdata, with idle cycles before each.
   task automatic feed_beats(input logic [255:0] line, input int gap);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap; g++) begin
            bus.burst_resp = 1'b0;
            tick();
         end
         bus.burst_rdata = line[i*64 +: 64];
         bus.burst_resp  = 1'b1;
         tick();
      end
      bus.burst_resp = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (bus.pmem_resp !== 1'b0) begin fails++; $display("FAIL reset_pmem_resp: got %b want 0", bus.pmem_resp); end
      checks++; if ({bus.burst_read, bus.burst_write} !== 2'b00) begin fails++; $display("FAIL reset_burst_rw: got %b want 00", {bus.burst_read, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0) begin fails++; $display("FAIL reset_address: got %h want 0", bus.burst_address); end
      checks++; if (bus.burst_wdata !== 64'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", bus.burst_wdata); end
      checks++; if (bus.pmem_rdata !== 256'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", bus.pmem_rdata); end
      rst = 1'b0;
      tick();
      checks++; if ({bus.pmem_resp, bus.burst_read, bus.burst_write} !== 3'b000) begin fails++; $display("FAIL reset_idle: got %b want 000", {bus.pmem_resp, bus.burst_read, bus.burst_write}); end
      $display("reset: done");
   endtask

   task automatic test_read();
      logic [255:0] exp_line;
      int start;
      exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      start = resp_seen;
      bus.pmem_address = 32'h0000_1234;
      bus.pmem_read    = 1'b1;
      tick();
      checks++; if ({bus.burst_read, bus.burst_write} !== 2'b10) begin fails++; $display("FAIL read_burst_rw: got %b want 10", {bus.burst_read, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0000_1220) begin fails++; $display("FAIL read_address: got %h want 00001220", bus.burst_address); end
      feed_beats(exp_line, 0);
      checks++; if (bus.pmem_resp !== 1'b1) begin fails++; $display("FAIL read_resp: got %b want 1", bus.pmem_resp); end
      checks++; if (bus.burst_read !== 1'b0) begin fails++; $display("FAIL read_done_burst_read: got %b want 0", bus.burst_read); end
      checks++; if (bus.pmem_rdata !== exp_line) begin fails++; $display("FAIL read_rdata: got %h want %h", bus.pmem_rdata, exp_line); end
      bus.pmem_read = 1'b0;
      tick();
      checks++; if (bus.pmem_resp !== 1'b0) begin fails++; $display("FAIL read_resp_single: got %b want 0", bus.pmem_resp); end
      checks++; if (bus.pmem_rdata !== exp_line) begin fails++; $display("FAIL read_rdata_held: got %h want %h", bus.pmem_rdata, exp_line); end
      checks++; if (resp_seen - start !== 1) begin fails++; $display("FAIL read_resp_count: got %0d want 1", resp_seen - start); end
      $display("read: addr 00001234 line %h", bus.pmem_rdata);
   endtask

   task automatic test_write_gaps();
      logic [63:0] wexp [4];
      logic [255:0] prev_rd;
      prev_rd = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      wexp[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      wexp[1] = 64'hBBBB_BBBB_BBBB_BBBB;
      wexp[2] = 64'hCCCC_CCCC_CCCC_CCCC;
      wexp[3] = 64'hDDDD_DDDD_DDDD_DDDD;
      bus.pmem_address = 32'h0000_2047;
      bus.pmem_wdata   = {wexp[3], wexp[2], wexp[1], wexp[0]};
      bus.pmem_write   = 1'b1;
      tick();
      checks++; if ({bus.burst_read, bus.burst_write} !== 2'b01) begin fails++; $display("FAIL write_burst_rw: got %b want 01", {bus.burst_read, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0000_2040) begin fails++; $display("FAIL write_address: got %h want 00002040", bus.burst_address); end
      // Cache-side changes after acceptance must not leak into the burst.
      bus.pmem_wdata   = '1;
      bus.pmem_address = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 2; g++) begin
            bus.burst_resp = 1'b0;
            checks++; if (bus.burst_wdata !== wexp[i]) begin fails++; $display("FAIL write_hold_beat%0d: got %h want %h", i, bus.burst_wdata, wexp[i]); end
            tick();
         end
         bus.burst_resp = 1'b1;
         checks++; if (bus.burst_wdata !== wexp[i]) begin fails++; $display("FAIL write_beat%0d: got %h want %h", i, bus.burst_wdata, wexp[i]); end
         tick();
         bus.burst_resp = 1'b0;
      end
      checks++; if ({bus.pmem_resp, bus.burst_write} !== 2'b10) begin fails++; $display("FAIL write_done: got %b want 10", {bus.pmem_resp, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0000_2040) begin fails++; $display("FAIL write_address_stable: got %h want 00002040", bus.burst_address); end
      checks++; if (bus.pmem_rdata !== prev_rd) begin fails++; $display("FAIL write_keeps_rdata: got %h want %h", bus.pmem_rdata, prev_rd); end
      bus.pmem_write = 1'b0;
      tick();
      $display("write: addr 00002040 gapped beats done");
   endtask

   task automatic test_back_to_back();
      logic [255:0] rd_line;
      int start;
      start   = resp_seen;
      rd_line = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                 64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
      bus.pmem_address = 32'h0000_0100;
      bus.pmem_wdata   = {4{64'h0123_4567_89AB_CDEF}};
      bus.pmem_write   = 1'b1;
      tick();
      feed_beats(256'h0, 0);
      checks++; if (bus.pmem_resp !== 1'b1) begin fails++; $display("FAIL b2b_write_resp: got %b want 1", bus.pmem_resp); end
      // Fill request appears while DONE; it must wait one cycle for IDLE.
      bus.pmem_write   = 1'b0;
      bus.pmem_read    = 1'b1;
      bus.pmem_address = 32'h0000_0200;
      tick();
      checks++; if ({bus.pmem_resp, bus.burst_read, bus.burst_write} !== 3'b000) begin fails++; $display("FAIL b2b_gap_idle: got %b want 000", {bus.pmem_resp, bus.burst_read, bus.burst_write}); end
      tick();
      checks++; if ({bus.burst_read, bus.burst_write} !== 2'b10) begin fails++; $display("FAIL b2b_read_start: got %b want 10", {bus.burst_read, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0000_0200) begin fails++; $display("FAIL b2b_read_address: got %h want 00000200", bus.burst_address); end
      feed_beats(rd_line, 0);
      checks++; if (bus.pmem_rdata !== rd_line) begin fails++; $display("FAIL b2b_rdata: got %h want %h", bus.pmem_rdata, rd_line); end
      bus.pmem_read = 1'b0;
      tick();
      checks++; if (resp_seen - start !== 2) begin fails++; $display("FAIL b2b_resp_count: got %0d want 2", resp_seen - start); end
      checks++; if (overlaps !== 0) begin fails++; $display("FAIL b2b_overlap: got %0d want 0", overlaps); end
      $display("back_to_back: write 00000100 then read 00000200 done");
   endtask

   task automatic test_reset_mid_read();
      logic [255:0] line_a;
      logic [255:0] line_b;
      int start;
      line_a = {64'hDEAD_0000_0000_0004, 64'hDEAD_0000_0000_0003,
                64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001};
      line_b = {64'h9999_AAAA_0000_0004, 64'h9999_AAAA_0000_0003,
                64'h9999_AAAA_0000_0002, 64'h9999_AAAA_0000_0001};
      start = resp_seen;
      bus.pmem_address = 32'h0000_3000;
      bus.pmem_read    = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         bus.burst_rdata = line_a[i*64 +: 64];
         bus.burst_resp  = 1'b1;
         tick();
      end
      bus.burst_resp = 1'b0;
      bus.pmem_read  = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if ({bus.pmem_resp, bus.burst_read, bus.burst_write} !== 3'b000) begin fails++; $display("FAIL abort_ctrl: got %b want 000", {bus.pmem_resp, bus.burst_read, bus.burst_write}); end
      checks++; if (bus.burst_address !== 32'h0) begin fails++; $display("FAIL abort_address: got %h want 0", bus.burst_address); end
      checks++; if (bus.pmem_rdata !== 256'h0) begin fails++; $display("FAIL abort_rdata: got %h want 0", bus.pmem_rdata); end
      rst = 1'b0;
      tick();
      checks++; if (resp_seen - start !== 0) begin fails++; $display("FAIL abort_no_resp: got %0d want 0", resp_seen - start); end
      bus.pmem_address = 32'h0000_3010;
      bus.pmem_read    = 1'b1;
      tick();
      checks++; if (bus.burst_address !== 32'h0000_3000) begin fails++; $display("FAIL abort_reread_address: got %h want 00003000", bus.burst_address); end
      feed_beats(line_b, 0);
      checks++; if (bus.pmem_resp !== 1'b1) begin fails++; $display("FAIL abort_reread_resp: got %b want 1", bus.pmem_resp); end
      checks++; if (bus.pmem_rdata !== line_b) begin fails++; $display("FAIL abort_reread_rdata: got %h want %h", bus.pmem_rdata, line_b); end
      bus.pmem_read = 1'b0;
      tick();
      $display("reset_mid_read: abort then reread 00003000 done");
   endtask

   task automatic test_both_high();
      logic [63:0] wexp [4];
      wexp[0] = 64'h0F0F_0F0F_0000_0001;
      wexp[1] = 64'h0F0F_0F0F_0000_0002;
      wexp[2] = 64'h0F0F_0F0F_0000_0003;
      wexp[3] = 64'h0F0F_0F0F_0000_0004;
      bus.pmem_address = 32'h0000_4000;
      bus.pmem_wdata   = {wexp[3], wexp[2], wexp[1], wexp[0]};
      bus.pmem_read    = 1'b1;
      bus.pmem_write   = 1'b1;
      #1;
      checks++; if (dut.both_req !== 1'b1) begin fails++; $display("FAIL both_flag: got %b want 1", dut.both_req); end
      tick();
      checks++; if ({bus.burst_read, bus.burst_write} !== 2'b01) begin fails++; $display("FAIL both_write_wins: got %b want 01", {bus.burst_read, bus.burst_write}); end
      for (int i = 0; i < 4; i++) begin
         bus.burst_resp = 1'b1;
         checks++; if (bus.burst_wdata !== wexp[i]) begin fails++; $display("FAIL both_beat%0d: got %h want %h", i, bus.burst_wdata, wexp[i]); end
         tick();
      end
      bus.burst_resp = 1'b0;
      checks++; if (bus.pmem_resp !== 1'b1) begin fails++; $display("FAIL both_resp: got %b want 1", bus.pmem_resp); end
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
      tick();
      $display("both_high: write burst at 00004000 done");
   endtask

   task automatic test_idle_resp();
      logic [255:0] line_c;
      int start;
      line_c = {64'hC0DE_0000_0000_0044, 64'hC0DE_0000_0000_0033,
                64'hC0DE_0000_0000_0022, 64'hC0DE_0000_0000_0011};
      start = resp_seen;
      bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      bus.burst_resp  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({bus.pmem_resp, bus.burst_read, bus.burst_write} !== 3'b000) begin fails++; $display("FAIL idle_resp_cycle%0d: got %b want 000", i, {bus.pmem_resp, bus.burst_read, bus.burst_write}); end
      end
      bus.burst_resp = 1'b0;
      checks++; if (resp_seen - start !== 0) begin fails++; $display("FAIL idle_resp_count: got %0d want 0", resp_seen - start); end
      // A following gapped read proves the beat counter was not advanced.
      bus.pmem_address = 32'h0000_5000;
      bus.pmem_read    = 1'b1;
      tick();
      feed_beats(line_c, 1);
      checks++; if (bus.pmem_rdata !== line_c) begin fails++; $display("FAIL idle_resp_rdata: got %h want %h", bus.pmem_rdata, line_c); end
      bus.pmem_read = 1'b0;
      tick();
      $display("idle_resp: stray strobes ignored, read 00005000 done");
   endtask

   initial begin
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.burst_rdata  = '0;
      bus.burst_resp   = 1'b0;
      test_reset();
      test_read();
      test_write_gaps();
      test_back_to_back();
      test_reset_mid_read();
      test_both_high();
      test_idle_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
